caf_peak_search: RTL and testbench

Streaming, framed arg-max engine for complex I/Q samples. It is the parametrised successor to the single-window arg-max block in the CAF datapath. It computes |x|² = xi² + xq² per sample and tracks the peak magnitude and its in-frame index over runtime-programmable frames. It emits one thresholded result per frame over a valid/ready handshake with full backpressure. It sits between the CAF correlator output and the peak-report logic.

---
 rtl/caf_peak_search.sv | 147 ++++++++++++++
 tb/tb_caf_peak_search.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/caf_peak_search.sv
// Framed streaming arg-max over |x|^2 of complex I/Q samples; one thresholded
// peak/index result per runtime-sized frame, valid/ready with full backpressure.
module caf_peak_search #(
  parameter int IQ_BITS      = 16,
  parameter int INDEX_BITS   = 10,
  parameter int OUT_MAX_BITS = 2*IQ_BITS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [IQ_BITS-1:0]      xi,
  input  logic signed [IQ_BITS-1:0]      xq,
  input  logic                           m_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [INDEX_BITS-1:0]          frame_len_m1,
  input  logic [OUT_MAX_BITS-1:0]        threshold,
  output logic [OUT_MAX_BITS-1:0]        out_max,
  output logic [INDEX_BITS-1:0]          index,
  output logic                           above,
  output logic                           s_axis_tvalid,
  input  logic                           m_axis_tready
);

  logic                     ready_en_q;

  logic [INDEX_BITS-1:0]    cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]    len_q, len_d;

  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic [OUT_MAX_BITS-1:0]  s1_mag_q, s1_mag_d;
  logic [INDEX_BITS-1:0]    s1_idx_q, s1_idx_d;

  logic [OUT_MAX_BITS-1:0]  acc_max_q, acc_max_d;
  logic [INDEX_BITS-1:0]    acc_idx_q, acc_idx_d;

  logic                     out_valid_q, out_valid_d;
  logic [OUT_MAX_BITS-1:0]  out_max_q, out_max_d;
  logic [INDEX_BITS-1:0]    out_idx_q, out_idx_d;
  logic                     out_above_q, out_above_d;

  logic signed [OUT_MAX_BITS-1:0] xi_ext, xq_ext, sq_i, sq_q;
  logic [OUT_MAX_BITS-1:0]  mag;
  logic [INDEX_BITS-1:0]    eff_len;
  logic                     cur_last;
  logic                     stall, accept, s1_take, load, take_new;
  logic [OUT_MAX_BITS-1:0]  cmp_max;
  logic [INDEX_BITS-1:0]    cmp_idx;

  // Sign-extend before squaring so the full-scale negative square cannot wrap.
  assign xi_ext = {{IQ_BITS{xi[IQ_BITS-1]}}, xi};
  assign xq_ext = {{IQ_BITS{xq[IQ_BITS-1]}}, xq};
  assign sq_i   = xi_ext * xi_ext;
  assign sq_q   = xq_ext * xq_ext;
  assign mag    = $unsigned(sq_i) + $unsigned(sq_q);

  assign stall         = s1_valid_q && s1_last_q && out_valid_q && !m_axis_tready;
  assign s_axis_tready = ready_en_q && !stall;
  assign accept        = m_axis_tvalid && s_axis_tready;

  // The frame length in force is the live input only for the index-0 sample.
  assign eff_len  = (cnt_q == '0) ? frame_len_m1 : len_q;
  assign cur_last = (cnt_q == eff_len);

  assign s1_take  = s1_valid_q && !stall;
  assign take_new = (s1_idx_q == '0) || (s1_mag_q > acc_max_q);
  assign cmp_max  = take_new ? s1_mag_q : acc_max_q;
  assign cmp_idx  = take_new ? s1_idx_q : acc_idx_q;
  assign load     = s1_take && s1_last_q;

  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    s1_mag_d    = s1_mag_q;
    s1_idx_d    = s1_idx_q;
    acc_max_d   = acc_max_q;
    acc_idx_d   = acc_idx_q;
    out_valid_d = out_valid_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_above_d = out_above_q;

    if (accept) begin
      cnt_d      = cur_last ? '0 : cnt_q + INDEX_BITS'(1);
      if (cnt_q == '0) len_d = frame_len_m1;
      s1_valid_d = 1'b1;
      s1_last_d  = cur_last;
      s1_mag_d   = mag;
      s1_idx_d   = cnt_q;
    end else if (!stall) begin
      s1_valid_d = 1'b0;
    end

    if (s1_take) begin
      acc_max_d = cmp_max;
      acc_idx_d = cmp_idx;
    end

    if (out_valid_q && m_axis_tready) out_valid_d = 1'b0;

    if (load) begin
      out_valid_d = 1'b1;
      out_max_d   = cmp_max;
      out_idx_d   = cmp_idx;
      out_above_d = (cmp_max >= threshold);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q  <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_idx_q    <= '0;
      acc_max_q   <= '0;
      acc_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_above_q <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_mag_q    <= s1_mag_d;
      s1_idx_q    <= s1_idx_d;
      acc_max_q   <= acc_max_d;
      acc_idx_q   <= acc_idx_d;
      out_valid_q <= out_valid_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_above_q <= out_above_d;
    end
  end

  assign s_axis_tvalid = out_valid_q;
  assign out_max       = out_max_q;
  assign index         = out_idx_q;
  assign above         = out_above_q;

endmodule

// File: tb/tb_caf_peak_search.sv
// Directed bench for caf_peak_search: table of whole-frame vectors plus
// hand sequences for backpressure, mid-frame reset and frame length changes.
module tb_caf_peak_search;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] xi, xq;
  logic               m_axis_tvalid;
  logic               s_axis_tready;
  logic [9:0]         frame_len_m1;
  logic [31:0]        threshold;
  logic [31:0]        out_max;
  logic [9:0]         index;
  logic               above;
  logic               s_axis_tvalid;
  logic               m_axis_tready;

  caf_peak_search #(.IQ_BITS(16), .INDEX_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n), .xi(xi), .xq(xq),
    .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
    .frame_len_m1(frame_len_m1), .threshold(threshold),
    .out_max(out_max), .index(index), .above(above),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] m;
    logic [9:0]  i;
    logic        a;
  } res_t;

  res_t res_q[$];

  // Transfers are fixed between the negedge and the following posedge.
  always @(negedge clk)
    if (rst_n && s_axis_tvalid && m_axis_tready)
      res_q.push_back('{m: out_max, i: index, a: above});

  typedef struct {
    logic [9:0]       len;
    int               n;
    logic [7:0][15:0] vi;
    logic [7:0][15:0] vq;
    logic [31:0]      thr;
    logic [31:0]      emax;
    logic [9:0]       eidx;
    logic             eab;
  } vec_t;

  vec_t vec[7];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int a, input int b);
    xi = 16'(a);
    xq = 16'(b);
    m_axis_tvalid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL send_timeout actual=no_accept required=accept");
  endtask

  task automatic get_result(input string name, input logic [31:0] em,
                            input logic [9:0] ei, input logic ea, input logic chk_a);
    res_t r;
    for (int c = 0; c < 100; c++) begin
      if (res_q.size() > 0) begin
        r = res_q.pop_front();
        chk({name, "_max"}, 64'(r.m), 64'(em));
        chk({name, "_idx"}, 64'(r.i), 64'(ei));
        if (chk_a) chk({name, "_above"}, 64'(r.a), 64'(ea));
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL %s_timeout actual=no_result required=result", name);
  endtask

  task automatic set_s(input int v, input int i, input int a, input int b);
    vec[v].vi[i] = 16'(a);
    vec[v].vq[i] = 16'(b);
  endtask

  task automatic set_v(input int v, input int len, input int n, input logic [31:0] thr,
                       input logic [31:0] emax, input int eidx, input logic eab);
    vec[v].len  = 10'(len);
    vec[v].n    = n;
    vec[v].thr  = thr;
    vec[v].emax = emax;
    vec[v].eidx = 10'(eidx);
    vec[v].eab  = eab;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_v(0, 7, 8, 32'd50000, 32'd50000, 5, 1'b1);
    set_s(0, 0, 1, 1);    set_s(0, 1, 10, 0);   set_s(0, 2, 0, 50);   set_s(0, 3, 100, 100);
    set_s(0, 4, -150, 0); set_s(0, 5, 100, -200); set_s(0, 6, 200, 0); set_s(0, 7, 0, -1);
    set_v(1, 3, 4, 32'd25, 32'd25, 0, 1'b1);
    for (int i = 0; i < 4; i++) set_s(1, i, 3, 4);
    set_v(2, 3, 4, 32'd26, 32'd25, 0, 1'b0);
    for (int i = 0; i < 4; i++) set_s(2, i, 3, 4);
    set_v(3, 0, 1, 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
    set_s(3, 0, -32768, -32768);
    set_v(4, 2, 3, 32'd100, 32'd49, 1, 1'b0);
    set_s(4, 0, 5, 0); set_s(4, 1, -7, 0); set_s(4, 2, 0, 7);
    set_v(5, 4, 5, 32'd0, 32'd162, 0, 1'b1);
    set_s(5, 0, 9, 9); set_s(5, 1, 1, 0); set_s(5, 2, 0, 0); set_s(5, 3, 2, 2); set_s(5, 4, 9, -9);
    set_v(6, 1, 2, 32'd1, 32'd0, 0, 1'b0);
    set_s(6, 0, 0, 0); set_s(6, 1, 0, 0);

    rst_n = 1'b0; xi = '0; xq = '0; m_axis_tvalid = 1'b0;
    frame_len_m1 = '0; threshold = '0; m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(s_axis_tvalid), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_out_max", 64'(out_max), 64'd0);
    chk("rst_index", 64'(index), 64'd0);
    chk("rst_above", 64'(above), 64'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_en_first_edge", 64'(s_axis_tready), 64'd0);
    @(negedge clk);
    chk("ready_en_set", 64'(s_axis_tready), 64'd1);

    for (int v = 0; v < 7; v++) begin
      sync();
      res_q.delete();
      frame_len_m1 = vec[v].len;
      threshold    = vec[v].thr;
      for (int i = 0; i < vec[v].n; i++) send(int'($signed(vec[v].vi[i])), int'($signed(vec[v].vq[i])));
      m_axis_tvalid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_lat_early", v), 64'(s_axis_tvalid), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_lat_valid", v), 64'(s_axis_tvalid), 64'd1);
      get_result($sformatf("v%0d", v), vec[v].emax, vec[v].eidx, vec[v].eab, 1'b1);
    end

    // Backpressure with one-sample frames, magnitudes 1, 2, 4.
    sync();
    res_q.delete();
    threshold = '0;
    frame_len_m1 = '0;
    m_axis_tready = 1'b0;
    send(1, 0);
    send(1, 1);
    xi = 16'sd2; xq = 16'sd0;
    @(negedge clk);
    chk("bp_tready_low", 64'(s_axis_tready), 64'd0);
    chk("bp_tvalid", 64'(s_axis_tvalid), 64'd1);
    chk("bp_first", 64'(out_max), 64'd1);
    repeat (3) @(negedge clk);
    chk("bp_hold_max", 64'(out_max), 64'd1);
    chk("bp_hold_tready", 64'(s_axis_tready), 64'd0);
    sync();
    m_axis_tready = 1'b1;
    send(2, 0);
    m_axis_tvalid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_count", 64'(res_q.size()), 64'd3);
    get_result("bp_r0", 32'd1, 10'd0, 1'b0, 1'b0);
    get_result("bp_r1", 32'd2, 10'd0, 1'b0, 1'b0);
    get_result("bp_r2", 32'd4, 10'd0, 1'b0, 1'b0);

    // Reset with an unread result and a partial frame in flight.
    sync();
    m_axis_tready = 1'b0;
    frame_len_m1 = 10'd1;
    send(1000, 0);
    send(0, 0);
    m_axis_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_stale_valid", 64'(s_axis_tvalid), 64'd1);
    chk("rr_stale_max", 64'(out_max), 64'd1000000);
    sync();
    frame_len_m1 = 10'd7;
    for (int i = 0; i < 3; i++) send(1000, 0);
    rst_n = 1'b0;
    m_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("rr_tvalid", 64'(s_axis_tvalid), 64'd0);
    chk("rr_tready", 64'(s_axis_tready), 64'd0);
    chk("rr_out_max", 64'(out_max), 64'd0);
    chk("rr_index", 64'(index), 64'd0);
    chk("rr_above", 64'(above), 64'd0);
    sync();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    res_q.delete();
    sync();
    send(1, 0); send(0, 1); send(3, 0); send(2, 2);
    for (int i = 0; i < 4; i++) send(0, 0);
    m_axis_tvalid = 1'b0;
    get_result("rr_post", 32'd9, 10'd2, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("rr_no_extra", 64'(res_q.size()), 64'd0);

    // frame_len_m1 changed mid-frame; also pauses with m_axis_tvalid low.
    sync();
    res_q.delete();
    frame_len_m1 = 10'd7;
    send(1, 0);
    frame_len_m1 = 10'd2;
    send(1, 0);
    send(1, 0);
    m_axis_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk("fl_no_early", 64'(res_q.size()), 64'd0);
    chk("fl_no_early_valid", 64'(s_axis_tvalid), 64'd0);
    sync();
    send(1, 0); send(1, 0); send(1, 0); send(20, 0); send(1, 0);
    m_axis_tvalid = 1'b0;
    get_result("fl_long", 32'd400, 10'd6, 1'b0, 1'b0);
    sync();
    send(1, 0); send(2, 0); send(3, 0);
    m_axis_tvalid = 1'b0;
    get_result("fl_short", 32'd9, 10'd2, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
